// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: fetch FSM states and queue entry layout.
package inst_prefetch_buffer_pkg;

   typedef enum logic [1:0] {
      PfIdle = 2'd0,
      PfReq  = 2'd1,
      PfDrop = 2'd2
   } pf_state_e;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
   } pf_entry_t;

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Instruction memory read channel: request held until ack, data returned with ack.
interface inst_prefetch_buffer_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/inst_prefetch_buffer_pf_fifo.sv
// Synchronous FIFO of {word address, instruction} entries; flush overrides push and pop.
module pf_fifo
   import inst_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic            flush,
   input  pf_entry_t       wdata,
   output pf_entry_t       head,
   output logic [CntW-1:0] count
);

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   pf_entry_t       mem_q [DEPTH];
   logic            do_push, do_pop;

   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count_q != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Sequential instruction prefetch queue between IF and a variable-latency instruction memory.
module inst_prefetch_buffer
   import inst_prefetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          inst_ren,
   input  logic [31:0]                   inst_addr,
   input  logic                          inst_take,
   output logic [31:0]                   inst_data,
   output logic                          inst_ready,
   inst_prefetch_buffer_if.master        imem
);

   localparam int unsigned CntW      = $clog2(DEPTH) + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
   localparam logic [31:0] ResetWord = {RESET_ADDR[31:2], 2'b00};

   pf_state_e       state_q, state_d;
   logic [31:0]     fetch_addr_q, fetch_addr_d;
   logic [31:0]     req_addr_q, req_addr_d;
   pf_entry_t       head, push_entry;
   logic [CntW-1:0] fifo_count;
   logic            empty, hit, miss, pop, push;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^inst_addr[1:0];

   assign empty = (fifo_count == '0);
   assign hit   = inst_ren & ~empty & (head.addr == inst_addr[31:2]);
   // Waiting on an empty queue for the address already being fetched is not a redirect.
   assign miss  = inst_ren & ~hit & ~(empty & (fetch_addr_q[31:2] == inst_addr[31:2]));
   assign pop   = hit & inst_take;
   assign push  = (state_q == PfReq) & imem.imem_ack & ~miss;

   assign push_entry = '{addr: req_addr_q[31:2], data: imem.imem_rdata};

   pf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (miss),
      .wdata (push_entry),
      .head  (head),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= PfIdle;
         fetch_addr_q <= ResetWord;
         req_addr_q   <= ResetWord;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_addr_d   = req_addr_q;
      fetch_addr_d = fetch_addr_q;
      if (miss) begin
         fetch_addr_d = {inst_addr[31:2], 2'b00};
      end else if (push) begin
         fetch_addr_d = fetch_addr_q + 32'd4;
      end
      unique case (state_q)
         PfIdle: begin
            if (!miss && (fifo_count < FullCnt)) begin
               req_addr_d = fetch_addr_q;
               state_d    = PfReq;
            end
         end
         PfReq: begin
            if (imem.imem_ack) begin
               state_d = PfIdle;
            end else if (miss) begin
               state_d = PfDrop;
            end
         end
         PfDrop: begin
            if (imem.imem_ack) state_d = PfIdle;
         end
         default: state_d = PfIdle;
      endcase
   end

   always_comb begin
      imem.imem_req  = (state_q == PfReq) || (state_q == PfDrop);
      imem.imem_addr = req_addr_q;
      inst_ready     = hit;
      inst_data      = hit ? head.data : 32'h0;
   end

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed bench for inst_prefetch_buffer with a latency-programmable memory and scoreboards.
module tb_inst_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        inst_ren;
   logic [31:0] inst_addr;
   logic        inst_take;
   logic [31:0] inst_data;
   logic        inst_ready;

   always #5 clk = ~clk;

   inst_prefetch_buffer_if bus ();

   inst_prefetch_buffer #(
      .DEPTH      (4),
      .RESET_ADDR (32'h0)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .inst_ren   (inst_ren),
      .inst_addr  (inst_addr),
      .inst_take  (inst_take),
      .inst_data  (inst_data),
      .inst_ready (inst_ready),
      .imem       (bus)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          mem_lat = 0;
   int          mem_wait = 0;
   logic        in_req = 1'b0;
   logic [31:0] held_addr = 32'h0;
   logic [31:0] exp_req [$];
   logic [31:0] sb [$];
   logic [31:0] pc;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory side: called just after a falling edge, answers after mem_lat wait cycles.
   task automatic mem_drive();
      if (bus.imem_req === 1'b1) begin
         if (!in_req) begin
            in_req    = 1'b1;
            held_addr = bus.imem_addr;
            if (exp_req.size() > 0) check("req_addr", bus.imem_addr, exp_req.pop_front());
         end else begin
            check("req_addr_stable", bus.imem_addr, held_addr);
         end
         if (mem_wait >= mem_lat) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = word_of(bus.imem_addr);
         end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hBAD0_BAD0;
            mem_wait++;
         end
      end else begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = 32'hBAD0_BAD0;
      end
   endtask

   task automatic end_cycle();
      @(posedge clk);
      if (!rst_n || bus.imem_ack) begin
         in_req   = 1'b0;
         mem_wait = 0;
      end
      @(negedge clk);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         mem_drive();
         #1;
         end_cycle();
      end
   endtask

   // IF model: walks PCs from start, consuming n instructions within budget cycles.
   task automatic run_if(input logic [31:0] start, input int n, input int budget);
      int got;
      got = 0;
      sb.delete();
      for (int i = 0; i < n; i++) sb.push_back(word_of(start + 32'(4 * i)));
      pc        = start;
      inst_ren  = 1'b1;
      inst_take = 1'b1;
      for (int c = 0; c < budget && got < n; c++) begin
         inst_addr = pc;
         mem_drive();
         #1;
         if (inst_ready) begin
            check("if_data", inst_data, sb.pop_front());
            pc = pc + 32'd4;
            got++;
         end
         end_cycle();
      end
      check("if_consumed", 32'(got), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n          = 1'b0;
      inst_ren       = 1'b1;
      inst_take      = 1'b0;
      inst_addr      = 32'h0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      @(negedge clk);
      idle_cycles(2);

      // Reset state
      mem_drive();
      #1;
      check("rst_req", 32'(bus.imem_req), 32'h0);
      check("rst_ready", 32'(inst_ready), 32'h0);
      check("rst_data", inst_data, 32'h0);
      end_cycle();

      // First fetch after reset, then fill while IF stalls
      rst_n = 1'b1;
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      exp_req.push_back(32'h8);
      exp_req.push_back(32'hC);
      exp_req.push_back(32'h10);
      mem_drive(); #1;
      check("c1_idle_req", 32'(bus.imem_req), 32'h0);
      end_cycle();
      mem_drive(); #1;
      check("c2_req", 32'(bus.imem_req), 32'h1);
      check("c2_not_ready", 32'(inst_ready), 32'h0);
      end_cycle();
      mem_drive(); #1;
      check("c3_ready", 32'(inst_ready), 32'h1);
      check("c3_data", inst_data, word_of(32'h0));
      end_cycle();
      idle_cycles(5);
      for (int i = 0; i < 3; i++) begin
         mem_drive(); #1;
         check("full_no_req", 32'(bus.imem_req), 32'h0);
         check("full_count", 32'(dut.fifo_count), 32'd4);
         end_cycle();
      end
      inst_take = 1'b1;
      mem_drive(); #1;
      check("pop_data", inst_data, word_of(32'h0));
      end_cycle();
      inst_take = 1'b0;
      inst_addr = 32'h4;
      mem_drive(); #1;
      check("after_pop_idle", 32'(bus.imem_req), 32'h0);
      check("after_pop_count", 32'(dut.fifo_count), 32'd3);
      end_cycle();
      run_if(32'h4, 3, 20);

      // Fill with 0x10..0x1C, then redirect to 0x40
      inst_take = 1'b0;
      inst_addr = 32'h10;
      idle_cycles(12);
      mem_drive(); #1;
      check("hold_count", 32'(dut.fifo_count), 32'd4);
      check("hold_data", inst_data, word_of(32'h10));
      end_cycle();
      inst_addr = 32'h40;
      mem_drive(); #1;
      check("miss_ready", 32'(inst_ready), 32'h0);
      check("miss_data", inst_data, 32'h0);
      end_cycle();
      exp_req.push_back(32'h40);
      mem_drive(); #1;
      check("miss_flushed", 32'(dut.fifo_count), 32'd0);
      check("miss_idle", 32'(bus.imem_req), 32'h0);
      end_cycle();
      mem_drive(); #1;
      check("miss_wait", 32'(inst_ready), 32'h0);
      end_cycle();
      mem_drive(); #1;
      check("miss_ready_40", 32'(inst_ready), 32'h1);
      check("miss_data_40", inst_data, word_of(32'h40));
      end_cycle();

      // Redirect during an acked request (data dropped), then miss during a slow REQ
      inst_addr = 32'h20;
      mem_drive(); #1;
      check("redir_ack_ready", 32'(inst_ready), 32'h0);
      end_cycle();
      mem_lat = 3;
      exp_req.push_back(32'h20);
      mem_drive(); #1;
      check("miss_beats_push", 32'(dut.fifo_count), 32'd0);
      check("redir_idle", 32'(bus.imem_req), 32'h0);
      end_cycle();
      inst_addr = 32'h80;
      mem_drive(); #1;
      check("slow_req", 32'(bus.imem_req), 32'h1);
      end_cycle();
      for (int i = 0; i < 3; i++) begin
         mem_drive(); #1;
         check("drop_req", 32'(bus.imem_req), 32'h1);
         check("drop_addr", bus.imem_addr, 32'h20);
         check("drop_ready", 32'(inst_ready), 32'h0);
         end_cycle();
      end
      mem_lat = 0;
      exp_req.push_back(32'h80);
      mem_drive(); #1;
      check("drop_idle", 32'(bus.imem_req), 32'h0);
      check("drop_discard", 32'(dut.fifo_count), 32'd0);
      end_cycle();
      mem_drive(); #1;
      check("refetch_wait", 32'(inst_ready), 32'h0);
      end_cycle();
      mem_drive(); #1;
      check("refetch_data", inst_data, word_of(32'h80));
      end_cycle();

      // Push and pop in the same cycle at count 2
      idle_cycles(1);
      mem_drive(); #1;
      check("pp_count_before", 32'(dut.fifo_count), 32'd2);
      end_cycle();
      inst_take = 1'b1;
      mem_drive(); #1;
      check("pp_push_now", 32'(bus.imem_ack), 32'h1);
      check("pp_pop_data", inst_data, word_of(32'h80));
      end_cycle();
      inst_take = 1'b0;
      inst_addr = 32'h84;
      mem_drive(); #1;
      check("pp_count_after", 32'(dut.fifo_count), 32'd2);
      end_cycle();
      run_if(32'h84, 4, 30);

      // inst_ren low: no hit, no flush, prefetch keeps going
      inst_ren  = 1'b0;
      inst_addr = 32'h5000;
      for (int i = 0; i < 6; i++) begin
         mem_drive(); #1;
         check("ren0_ready", 32'(inst_ready), 32'h0);
         check("ren0_data", inst_data, 32'h0);
         end_cycle();
      end
      inst_ren  = 1'b1;
      inst_take = 1'b0;
      inst_addr = 32'h94;
      mem_drive(); #1;
      check("ren1_hit", inst_data, word_of(32'h94));
      end_cycle();

      // Fetch address wraps at the top of memory
      idle_cycles(10);
      exp_req.push_back(32'hFFFF_FFF8);
      exp_req.push_back(32'hFFFF_FFFC);
      exp_req.push_back(32'h0);
      exp_req.push_back(32'h4);
      run_if(32'hFFFF_FFF8, 4, 40);
      check("wrap_reqs_seen", 32'(exp_req.size()), 32'd0);

      // Reset in the middle of an outstanding request
      inst_take = 1'b0;
      inst_addr = 32'h8;
      idle_cycles(10);
      mem_lat   = 50;
      inst_addr = 32'h200;
      exp_req.push_back(32'h200);
      idle_cycles(2);
      mem_drive(); #1;
      check("midreq_req", 32'(bus.imem_req), 32'h1);
      rst_n = 1'b0;
      end_cycle();
      mem_drive(); #1;
      check("midreq_rst_req", 32'(bus.imem_req), 32'h0);
      check("midreq_rst_ready", 32'(inst_ready), 32'h0);
      rst_n     = 1'b1;
      mem_lat   = 0;
      inst_addr = 32'h0;
      exp_req.push_back(32'h0);
      end_cycle();
      mem_drive(); #1;
      check("restart_req", 32'(bus.imem_req), 32'h1);
      end_cycle();
      mem_drive(); #1;
      check("restart_data", inst_data, word_of(32'h0));
      check("restart_reqs_seen", 32'(exp_req.size()), 32'd0);
      end_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
